// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state codes and the
// default cycle counts for a 48 MHz PLL output clock.
package pll_rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD_SYS  = 2'd1,
      ST_HOLD_CPU  = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_SYS_HOLD_CYCLES    = 256;
   localparam int unsigned DEF_CPU_HOLD_CYCLES    = 4800;   // 100 us
   localparam int unsigned DEF_DEBOUNCE_CYCLES    = 48000;  // 1 ms

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_rst_seq_debounce.sv
// Button conditioner: 2-FF synchronizer followed by a stable-level counter.
// The output follows the synchronized input only after CYCLES unequal cycles.
module debounce
   import pll_rst_seq_pkg::*;
#(
   parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic resetn,
   input  logic din,
   output logic dout
);

   localparam int unsigned    CW   = $clog2(CYCLES) + 1;
   localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   // Both flops reset to the released (high) level so no press is seen at start-up
   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta <= 1'b1;
         sync <= 1'b1;
      end else begin
         meta <= din;
         sync <= meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt  <= '0;
         dout <= 1'b1;
      end else if (sync == dout) begin
         cnt  <= '0;
      end else if (cnt == LAST) begin
         dout <= sync;
         cnt  <= '0;
      end else begin
         cnt  <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pll_rst_seq.sv
// Reset sequencer: waits for a stable PLL lock, releases the system reset,
// then the CPU RESB; handles the debounced reset button and sticky lock loss.
module pll_rst_seq
   import pll_rst_seq_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned SYS_HOLD_CYCLES    = DEF_SYS_HOLD_CYCLES,
   parameter int unsigned CPU_HOLD_CYCLES    = DEF_CPU_HOLD_CYCLES,
   parameter int unsigned DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       pll_locked_i,
   input  logic       btn_resetn_i,
   output logic       sys_resetn_o,
   output logic       cpu_resb_o,
   output logic       run_o,
   output logic       lock_lost_o,
   output logic [1:0] state_o
);

   localparam int unsigned   MAX_HOLD = max3(LOCK_STABLE_CYCLES, SYS_HOLD_CYCLES,
                                             CPU_HOLD_CYCLES);
   localparam int unsigned   CW       = $clog2(MAX_HOLD) + 1;
   localparam logic [CW-1:0] L_LAST   = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] S_LAST   = CW'(SYS_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] C_LAST   = CW'(CPU_HOLD_CYCLES - 1);

   logic          lock_meta;
   logic          locked_s;
   logic          btn_db;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          lost_nxt;
   logic          sys_nxt;
   logic          cpu_nxt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         lock_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         lock_meta <= pll_locked_i;
         locked_s  <= lock_meta;
      end
   end

   debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_db (
      .clk    (clk),
      .resetn (resetn),
      .din    (btn_resetn_i),
      .dout   (btn_db)
   );

   // Lock loss is tested first in every post-lock state, then the button,
   // then hold expiry, which gives the required priority ordering.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      lost_nxt  = lock_lost_o;

      case (state)
         ST_WAIT_LOCK: begin
            if (!locked_s) begin
               cnt_nxt = '0;
            end else if (cnt == L_LAST) begin
               state_nxt = ST_HOLD_SYS;
               cnt_nxt   = '0;
            end
         end
         ST_HOLD_SYS: begin
            if (!locked_s) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
               lost_nxt  = 1'b1;
            end else if (cnt == S_LAST) begin
               state_nxt = ST_HOLD_CPU;
               cnt_nxt   = '0;
            end
         end
         ST_HOLD_CPU: begin
            if (!locked_s) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
               lost_nxt  = 1'b1;
            end else if (!btn_db) begin
               cnt_nxt = '0;
            end else if (cnt == C_LAST) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            cnt_nxt = '0;
            if (!locked_s) begin
               state_nxt = ST_WAIT_LOCK;
               lost_nxt  = 1'b1;
            end else if (!btn_db) begin
               state_nxt = ST_HOLD_CPU;
            end
         end
         default: begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
         end
      endcase

      sys_nxt = (state_nxt == ST_HOLD_CPU) || (state_nxt == ST_RUN);
      cpu_nxt = (state_nxt == ST_RUN);
   end

   // Outputs are decoded from the next state so they move with state_o
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ST_WAIT_LOCK;
         cnt          <= '0;
         sys_resetn_o <= 1'b0;
         cpu_resb_o   <= 1'b0;
         run_o        <= 1'b0;
         lock_lost_o  <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         sys_resetn_o <= sys_nxt;
         cpu_resb_o   <= cpu_nxt;
         run_o        <= cpu_nxt;
         lock_lost_o  <= lost_nxt;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with L=8, S=4, C=6, D=5: a vector table for
// lock glitch and power-up, plus hand-written multi-cycle sequences.
module tb_pll_rst_seq;

   logic       clk = 1'b0;
   logic       resetn;
   logic       pll_locked_i;
   logic       btn_resetn_i;
   logic       sys_resetn_o;
   logic       cpu_resb_o;
   logic       run_o;
   logic       lock_lost_o;
   logic [1:0] state_o;

   int checks   = 0;
   int failures = 0;

   pll_rst_seq #(
      .LOCK_STABLE_CYCLES (8),
      .SYS_HOLD_CYCLES    (4),
      .CPU_HOLD_CYCLES    (6),
      .DEBOUNCE_CYCLES    (5)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .pll_locked_i (pll_locked_i),
      .btn_resetn_i (btn_resetn_i),
      .sys_resetn_o (sys_resetn_o),
      .cpu_resb_o   (cpu_resb_o),
      .run_o        (run_o),
      .lock_lost_o  (lock_lost_o),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rstn;
      logic       lk;
      logic       btn;
      int         n;
      logic       sys;
      logic       cpu;
      logic       run;
      logic       lost;
      logic [1:0] st;
   } vec_t;

   localparam int NV = 13;
   vec_t tbl [0:NV-1];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic sys, input logic cpu,
                          input logic run, input logic lost, input logic [1:0] st);
      chk({tag, ".sys_resetn"}, {31'd0, sys_resetn_o}, {31'd0, sys});
      chk({tag, ".cpu_resb"},   {31'd0, cpu_resb_o},   {31'd0, cpu});
      chk({tag, ".run"},        {31'd0, run_o},        {31'd0, run});
      chk({tag, ".lock_lost"},  {31'd0, lock_lost_o},  {31'd0, lost});
      chk({tag, ".state"},      {30'd0, state_o},      {30'd0, st});
   endtask

   initial begin
      bit reached;

      resetn       = 1'b0;
      pll_locked_i = 1'b0;
      btn_resetn_i = 1'b1;

      // Lock glitch in WAIT_LOCK: locked_s returns after edge 8, so HOLD_SYS at edge 16
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      // Power-up: HOLD_SYS after edge 10, sys release after 14, RUN after 20
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};

      #2;
      for (int i = 0; i < NV; i++) begin
         resetn       = tbl[i].rstn;
         pll_locked_i = tbl[i].lk;
         btn_resetn_i = tbl[i].btn;
         step(tbl[i].n);
         chk_all($sformatf("vec%0d", i), tbl[i].sys, tbl[i].cpu, tbl[i].run,
                 tbl[i].lost, tbl[i].st);
      end

      // Lock loss in RUN: resets low at edge 3, then a full relock sequence
      pll_locked_i = 1'b0;
      step(2);
      chk_all("drop_e2", 1'b1, 1'b1, 1'b1, 1'b0, 2'd3);
      step(1);
      chk_all("drop_e3", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      pll_locked_i = 1'b1;
      step(13);
      chk_all("relock_e13", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      step(1);
      chk_all("relock_e14", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      step(5);
      chk_all("relock_e19", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      step(1);
      chk_all("relock_e20", 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);

      // Bouncing button: runs of 2 never satisfy the debounce counter
      for (int i = 0; i < 20; i++) begin
         btn_resetn_i = ((i / 2) % 2) != 0;
         step(1);
         chk($sformatf("bounce%0d.cpu_resb", i), {31'd0, cpu_resb_o}, 32'd1);
      end
      btn_resetn_i = 1'b1;
      step(6);
      chk_all("bounce_after", 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);

      // Steady press for 10 cycles: drop at edge 8, btn_db high after 17, RUN at 23
      btn_resetn_i = 1'b0;
      step(7);
      chk_all("press_e7", 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
      step(1);
      chk_all("press_e8", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      step(2);
      btn_resetn_i = 1'b1;
      step(12);
      chk_all("press_e22", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      step(1);
      chk_all("press_e23", 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);

      // Debounced press and lock drop reach the FSM on the same edge (8)
      btn_resetn_i = 1'b0;
      step(5);
      pll_locked_i = 1'b0;
      step(2);
      chk_all("simul_e7", 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
      step(1);
      chk_all("simul_e8", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      btn_resetn_i = 1'b1;
      pll_locked_i = 1'b1;

      // resetn while in HOLD_CPU clears everything, including lock_lost_o
      reached = 1'b0;
      for (int i = 0; i < 60 && !reached; i++) begin
         step(1);
         if (state_o == 2'd2) reached = 1'b1;
      end
      chk("reach_hold_cpu", {31'd0, reached}, 32'd1);
      chk("hold_cpu.lock_lost", {31'd0, lock_lost_o}, 32'd1);
      resetn = 1'b0;
      step(1);
      chk_all("rst_hold_cpu", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      resetn = 1'b1;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
